// File: rtl/map_table_pkg.sv
// Shared constants, map-entry type and the per-entry update rule used by both
// the live rename table and its branch snapshot.
package map_table_pkg;

  localparam int NUM_PR   = 64;
  localparam int NUM_ARCH = 32;
  localparam int TAG_W    = $clog2(NUM_PR);
  localparam int ARCH_W   = $clog2(NUM_ARCH);

  localparam logic [ARCH_W-1:0] ZERO_REG = 5'd31;
  localparam logic [TAG_W-1:0]  ZERO_PR  = 6'd31;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             ready;
  } map_entry_t;

  // CDB wakeup first, then an optional dispatch write that overrides it.
  // The zero register is pinned to its fixed mapping.
  function automatic map_entry_t next_entry(
    input map_entry_t        cur,
    input logic [ARCH_W-1:0] idx,
    input logic              cdb_valid,
    input logic [TAG_W-1:0]  cdb_tag,
    input logic              wr_en,
    input logic [ARCH_W-1:0] wr_idx,
    input logic [TAG_W-1:0]  wr_tag
  );
    map_entry_t nxt;
    nxt = cur;
    if (cdb_valid && (cur.tag == cdb_tag)) nxt.ready = 1'b1;
    if (wr_en && (wr_idx == idx)) begin
      nxt.tag   = wr_tag;
      nxt.ready = 1'b0;
    end
    if (idx == ZERO_REG) begin
      nxt.tag   = ZERO_PR;
      nxt.ready = 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/map_table.sv
// Register rename map table: 32 arch->phys mappings with ready bits, one
// branch snapshot, CDB wakeup and single-cycle rollback.
module map_table
  import map_table_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_en,
  input  logic [ARCH_W-1:0] dest_idx,
  input  logic [ARCH_W-1:0] rega_idx,
  input  logic [ARCH_W-1:0] regb_idx,
  input  logic [TAG_W-1:0]  T_idx,
  input  logic              CDB_valid,
  input  logic [TAG_W-1:0]  CDB_T_idx,
  input  logic              checkpoint_en,
  input  logic              rollback_en,
  output logic [TAG_W-1:0]  T_old_idx,
  output logic [TAG_W-1:0]  T1_idx,
  output logic [TAG_W-1:0]  T2_idx,
  output logic              T1_ready,
  output logic              T2_ready
);

  map_entry_t r_table [NUM_ARCH];
  map_entry_t r_snap  [NUM_ARCH];

  map_entry_t w_table_upd  [NUM_ARCH];
  map_entry_t w_snap_upd   [NUM_ARCH];
  map_entry_t w_table_next [NUM_ARCH];
  map_entry_t w_snap_next  [NUM_ARCH];

  logic w_disp_wr;
  logic w_take_ckpt;

  assign w_disp_wr   = dispatch_en && !rollback_en && (dest_idx != ZERO_REG);
  assign w_take_ckpt = checkpoint_en && !rollback_en;

  generate
    for (genvar gi = 0; gi < NUM_ARCH; gi++) begin : g_entry
      assign w_table_upd[gi] = next_entry(r_table[gi], ARCH_W'(gi), CDB_valid, CDB_T_idx,
                                          w_disp_wr, dest_idx, T_idx);
      // The snapshot only ever sees CDB wakeups while held.
      assign w_snap_upd[gi]  = next_entry(r_snap[gi], ARCH_W'(gi), CDB_valid, CDB_T_idx,
                                          1'b0, dest_idx, T_idx);

      assign w_table_next[gi] = rollback_en ? w_snap_upd[gi] : w_table_upd[gi];
      assign w_snap_next[gi]  = w_take_ckpt ? w_table_upd[gi] : w_snap_upd[gi];

      always_ff @(posedge clock) begin
        if (reset) begin
          r_table[gi] <= '{tag: TAG_W'(gi), ready: 1'b1};
          r_snap[gi]  <= '{tag: TAG_W'(gi), ready: 1'b1};
        end else begin
          r_table[gi] <= w_table_next[gi];
          r_snap[gi]  <= w_snap_next[gi];
        end
      end
    end
  endgenerate

  // Reads come from the current table so a source never sees its own dest write.
  assign T_old_idx = (dest_idx == ZERO_REG) ? ZERO_PR : r_table[dest_idx].tag;
  assign T1_idx    = r_table[rega_idx].tag;
  assign T2_idx    = r_table[regb_idx].tag;
  assign T1_ready  = r_table[rega_idx].ready || (CDB_valid && (CDB_T_idx == T1_idx));
  assign T2_ready  = r_table[regb_idx].ready || (CDB_valid && (CDB_T_idx == T2_idx));

endmodule

// File: doc/map_table.md
MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 clock  input  1  system clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 dispatch_en  input  1  one instruction is renamed this cycle.
REQ-004 dest_idx  input  5  architectural destination of the dispatching instruction.
REQ-005 rega_idx, regb_idx  input  5 each  architectural sources of the dispatching instruction.
REQ-006 T_idx  input  6  physical register supplied by the free list for dest_idx.
REQ-007 CDB_valid  input  1  a completion broadcast is present this cycle.
REQ-008 CDB_T_idx  input  6  physical tag being broadcast.
REQ-009 checkpoint_en  input  1  branch dispatch: take a snapshot this cycle.
REQ-010 rollback_en  input  1  mispredict: restore from the snapshot.
REQ-011 T_old_idx  output  6  current mapping of dest_idx; this is the previous tag handed to ROB/free list.
REQ-012 T1_idx, T2_idx  output  6 each  current mappings of rega_idx and regb_idx.
REQ-013 T1_ready, T2_ready  output  1 each  the source value is available, including a same-cycle CDB hit.

Function
REQ-014 The table shall hold, per architectural register 0..31, a 6-bit tag and a ready bit.
REQ-015 All outputs shall be combinational reads of the current table, not of next state.
  - An instruction's sources never see its own destination write.
REQ-016 T1_ready shall be ready[rega_idx] OR (CDB_valid AND CDB_T_idx == T1_idx); T2_ready follows the same rule for regb_idx.
REQ-017 T_old_idx shall equal tag[dest_idx].
  - If dest_idx == ZERO_REG (31), T_old_idx shall be ZERO_PR (31).
REQ-018 When dispatch_en is high, dest_idx != ZERO_REG and rollback_en is low:
  - next tag[dest_idx] = T_idx;
  - next ready[dest_idx] = 0.
REQ-019 When CDB_valid is high, every entry whose tag == CDB_T_idx shall set ready = 1 next cycle.
  - If an entry is also written by dispatch in the same cycle, the dispatch write wins for that entry.
REQ-020 Entry ZERO_REG shall always hold tag ZERO_PR with ready = 1.
  - Writes to it are ignored.
REQ-021 When checkpoint_en is high and rollback_en is low, the snapshot shall capture the table's next state, including that cycle's dispatch and CDB updates.
REQ-022 While held, the snapshot's ready bits shall also be set by CDB broadcasts matching snapshot tags.
REQ-023 When rollback_en is high, next table shall equal the snapshot.
  - A same-cycle CDB hit shall also set ready in the restored entries.
  - Dispatch and checkpoint_en shall be ignored that cycle.
REQ-024 Only one snapshot shall exist; a new checkpoint_en overwrites it.
  - Rollback without a prior checkpoint restores the reset mapping.
REQ-025 Simultaneous checkpoint_en and rollback_en: rollback wins; the snapshot is left unchanged.

Reset
REQ-026 On reset, table and snapshot shall both be set to tag[i] = i and ready[i] = 1 for i = 0..31.
  - The outputs reflect this mapping in the next cycle.
  - This matches a free list initialised with PR 32..63.
REQ-027 Reset shall override dispatch, CDB, checkpoint and rollback in the same cycle.

Structure
REQ-028 NUM_PR (64), NUM_ARCH (32), ZERO_REG (31) and ZERO_PR (31) shall live in the shared package.
  - The package shall also define a map-entry typedef {tag[5:0], ready}.
REQ-029 The block shall be a single module; no sub-module is required.
  - The 32-entry table and the snapshot share one update function applied to two arrays.

Verification
REQ-030 Reset, then rega_idx=3, regb_idx=31 -> T1_idx=3, T1_ready=1, T2_idx=31, T2_ready=1.
REQ-031 Dispatch dest=5, T_idx=40 -> same cycle T_old_idx=5; next cycle tag[5]=40, ready=0; then CDB_T_idx=40 -> T1_ready=1 combinationally, ready[5]=1 next cycle.
REQ-032 Dispatch dest=31, T_idx=33 -> T_old_idx=31; entry 31 unchanged (tag 31, ready 1).
REQ-033 Dispatch dest=7, T_idx=45 with checkpoint_en, then dest=7, T_idx=50, then rollback_en -> tag[7]=45 after rollback.
  - A CDB of 45 between checkpoint and rollback leaves ready[7]=1 after rollback.
REQ-034 rollback_en with dispatch_en (dest=9, T_idx=60) in the same cycle -> tag[9] comes from the snapshot, not 60.
REQ-035 Assert reset during a dispatch cycle -> next cycle tag[i]=i and ready[i]=1 for all i, snapshot also at reset values.
